// File: rtl/mux_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_pipe_stage_if
// Description : Source-select bus plus valid/ready handshake of mux_pipe_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_pipe_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_badsel;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_bus, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_badsel, out_valid
    );

    modport slave (
        input  in_bus, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_badsel, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : mux_pipe_stage
// Description : N-way source select into a 1-cycle registered stage with
//               valid/ready handshake, 2-entry skid buffer and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_pipe_stage #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter int               SEL_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux_pipe_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main_data;
    logic [SEL_W-1:0] r_main_sel;
    logic             r_main_bad;
    logic [WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0] r_skid_sel;
    logic             r_skid_bad;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [WIDTH-1:0] w_mux_data;
    logic             w_badsel;
    logic             w_accept;
    logic             w_consume;

    always_comb begin
        w_mux_data = RESET_VAL;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                w_mux_data = bus.in_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // With a fully populated select range no index can be out of range.
    if (NUM_IN == (1 << SEL_W)) begin : g_full_sel
        assign w_badsel = 1'b0;
    end else begin : g_partial_sel
        assign w_badsel = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN));
    end

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_consume = r_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_data <= RESET_VAL;
            r_main_sel  <= '0;
            r_main_bad  <= 1'b0;
            r_skid_data <= RESET_VAL;
            r_skid_sel  <= '0;
            r_skid_bad  <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_data <= RESET_VAL;
            r_main_sel  <= '0;
            r_main_bad  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= w_mux_data;
                        r_main_sel  <= bus.sel;
                        r_main_bad  <= w_badsel;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                    r_in_ready <= 1'b1;
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        r_main_data <= w_mux_data;
                        r_main_sel  <= bus.sel;
                        r_main_bad  <= w_badsel;
                        r_in_ready  <= 1'b1;
                    end else if (w_accept) begin
                        // Main is stalled; park the new beat in the skid slot.
                        r_skid_data <= w_mux_data;
                        r_skid_sel  <= bus.sel;
                        r_skid_bad  <= w_badsel;
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_consume) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_consume) begin
                        r_main_data <= r_skid_data;
                        r_main_sel  <= r_skid_sel;
                        r_main_bad  <= r_skid_bad;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data   = r_main_data;
    assign bus.out_sel    = r_main_sel;
    assign bus.out_badsel = r_main_bad;
    assign bus.out_valid  = r_out_valid;
    assign bus.in_ready   = r_in_ready;
endmodule
`default_nettype wire
